// File: rtl/md5_pkg.sv
// md5_pkg: shared MD5 constants, round-function enum, message schedule and FSM states.
package md5_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {FN_F, FN_G, FN_H, FN_I} fn_e;
  localparam logic [31:0] K [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };
  localparam logic [4:0] ROT [4][4] = '{
    '{5'd7, 5'd12, 5'd17, 5'd22},
    '{5'd5, 5'd9,  5'd14, 5'd20},
    '{5'd4, 5'd11, 5'd16, 5'd23},
    '{5'd6, 5'd10, 5'd15, 5'd21}
  };
  function automatic logic [3:0] msg_idx(input logic [5:0] i);
    return i[5:4] == 2'd0 ? i[3:0] :
           i[5:4] == 2'd1 ? 4'(5 * i + 1) :
           i[5:4] == 2'd2 ? 4'(3 * i + 5) : 4'(7 * i);
  endfunction
  function automatic logic [127:0] add4(input logic [127:0] x, input logic [127:0] y);
    for (int w = 0; w < 4; w++) add4[32*w +: 32] = x[32*w +: 32] + y[32*w +: 32];
  endfunction
endpackage

// File: rtl/md5_step.sv
// md5_step: one combinational MD5 step for step index idx.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [5:0]  idx,
  output logic [31:0] a_n,
  output logic [31:0] b_n,
  output logic [31:0] c_n,
  output logic [31:0] d_n
);
  fn_e         fn;
  logic [31:0] f, sum;
  logic [63:0] dbl;
  always_comb begin
    fn  = fn_e'(idx[5:4]);
    f   = fn == FN_F ? (b & c) | (~b & d) :
          fn == FN_G ? (b & d) | (c & ~d) :
          fn == FN_H ? b ^ c ^ d : c ^ (b | ~d);
    sum = a + f + K[idx] + m;
    dbl = {sum, sum} << ROT[idx[5:4]][idx[1:0]];
    a_n = d;
    b_n = b + dbl[63:32];
    c_n = b;
    d_n = c;
  end
endmodule

// File: rtl/md5_compress.sv
// md5_compress: iterative MD5 compression, STEPS_PER_CYCLE steps per clock,
// valid/ready on both sides, result held in DONE until taken.
module md5_compress
  import md5_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1,
  parameter bit ADD_CHAIN       = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int S = STEPS_PER_CYCLE;
  state_e       st, st_n;
  logic [5:0]   i;
  logic [127:0] work, chain, res;
  logic [511:0] blk;
  logic         last;
  for (genvar k = 0; k < S; k++) begin : g_step
    logic [127:0] cur, nxt;
    logic [5:0]   idx;
    if (k == 0) begin : g_first
      assign cur = work;
    end else begin : g_next
      assign cur = g_step[k-1].nxt;
    end
    assign idx = i + 6'(k);
    md5_step u_step (
      .a(cur[31:0]), .b(cur[63:32]), .c(cur[95:64]), .d(cur[127:96]),
      .m(blk[32*msg_idx(idx) +: 32]), .idx(idx),
      .a_n(nxt[31:0]), .b_n(nxt[63:32]), .c_n(nxt[95:64]), .d_n(nxt[127:96])
    );
  end
  assign res       = g_step[S-1].nxt;
  assign last      = i == 6'(64 - S);
  assign in_ready  = st == IDLE;
  assign out_valid = st == DONE;
  assign busy      = st != IDLE;
  always_comb begin
    st_n = st == IDLE ? (in_valid ? RUN : IDLE) :
           st == RUN  ? (last ? DONE : RUN) :
                        (out_ready ? IDLE : DONE);
  end
  // i is a multiple of S, so the final advance wraps it back to 0 exactly on leaving RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      i         <= '0;
      work      <= '0;
      chain     <= '0;
      blk       <= '0;
      out_state <= '0;
    end else begin
      st <= st_n;
      if (st == IDLE && in_valid) begin
        work  <= in_state;
        chain <= in_state;
        blk   <= in_block;
        i     <= '0;
      end
      if (st == RUN) begin
        work <= res;
        i    <= i + 6'(S);
        if (last) out_state <= ADD_CHAIN ? add4(chain, res) : res;
      end
    end
  end
endmodule

// File: tb/tb_md5_compress.sv
// tb_md5_compress: scoreboard bench for two md5_compress builds (S=1 chained, S=4 raw)
// against a sin()-derived MD5 reference model.
module tb_md5_compress;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic va = 0, ra, ova, ora = 1, busy_a;
  logic [127:0] st_a = '0, out_a;
  logic [511:0] bk_a = '0;
  logic vb = 0, rb, ovb, orb = 1, busy_b;
  logic [127:0] st_b = '0, out_b;
  logic [511:0] bk_b = '0;

  md5_compress #(.STEPS_PER_CYCLE(1), .ADD_CHAIN(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(ra), .in_state(st_a), .in_block(bk_a),
    .out_valid(ova), .out_ready(ora), .out_state(out_a), .busy(busy_a));
  md5_compress #(.STEPS_PER_CYCLE(4), .ADD_CHAIN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rb), .in_state(st_b), .in_block(bk_b),
    .out_valid(ovb), .out_ready(orb), .out_state(out_b), .busy(busy_b));

  localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] EMPTY_RES = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] ABC_RES   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
  logic [511:0] empty_blk, abc_blk;

  int total = 0, bad = 0;
  int unsigned kk [64];
  logic [127:0] qa[$], qb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  function automatic logic [127:0] ref_md5(input logic [127:0] iv, input logic [511:0] b, input bit add);
    int unsigned m [16];
    int unsigned a, bb, c, d, f, t, s0;
    int unsigned g;
    int sh [4][4] = '{'{7, 12, 17, 22}, '{5, 9, 14, 20}, '{4, 11, 16, 23}, '{6, 10, 15, 21}};
    for (int j = 0; j < 16; j++) m[j] = b[32*j +: 32];
    a = iv[31:0]; bb = iv[63:32]; c = iv[95:64]; d = iv[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (bb & c) | (~bb & d); g = i; end
      else if (i < 32) begin f = (bb & d) | (c & ~d);  g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = bb ^ c ^ d;           g = (3 * i + 5) % 16; end
      else             begin f = c ^ (bb | ~d);        g = (7 * i) % 16; end
      s0 = sh[i / 16][i % 4];
      t = a + f + kk[i] + m[g];
      t = (t << s0) | (t >> (32 - s0));
      a = d; d = c; c = bb; bb = bb + t;
    end
    if (add) begin
      a += iv[31:0]; bb += iv[63:32]; c += iv[95:64]; d += iv[127:96];
    end
    return {d, c, bb, a};
  endfunction

  function automatic logic [127:0] sub4(input logic [127:0] x, input logic [127:0] y);
    for (int w = 0; w < 4; w++) sub4[32*w +: 32] = x[32*w +: 32] - y[32*w +: 32];
  endfunction

  function automatic logic [511:0] rnd512();
    for (int w = 0; w < 16; w++) rnd512[32*w +: 32] = $urandom;
  endfunction

  function automatic logic [127:0] rnd128();
    for (int w = 0; w < 4; w++) rnd128[32*w +: 32] = $urandom;
  endfunction

  always @(negedge clk) begin
    if (rst_n && ova && ora) begin
      if (qa.size() == 0) fail("a_unexpected_output");
      else check("a_result", out_a, qa.pop_front());
    end
    if (rst_n && ovb && orb) begin
      if (qb.size() == 0) fail("b_unexpected_output");
      else check("b_result", out_b, qb.pop_front());
    end
  end

  task automatic send(input bit sel, input logic [127:0] s, input logic [511:0] b, output int waited);
    waited = 0;
    if (sel) begin vb = 1; st_b = s; bk_b = b; end
    else begin va = 1; st_a = s; bk_a = b; end
    while (!(sel ? rb : ra) && waited < 300) begin
      @(posedge clk); #1; waited++;
    end
    if (!(sel ? rb : ra)) fail("accept_timeout");
    if (sel) qb.push_back(ref_md5(s, b, 0));
    else qa.push_back(ref_md5(s, b, 1));
    @(posedge clk); #1;
    if (sel) vb = 0; else va = 0;
  endtask

  task automatic wait_out(input bit sel, input int exp_n, input string name);
    int n = 0;
    while (!(sel ? ovb : ova) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check(name, n, exp_n);
  endtask

  initial begin
    int w;
    logic [127:0] snap;
    for (int i = 0; i < 64; i++) begin
      real x;
      x = $sin(i + 1);
      if (x < 0.0) x = -x;
      kk[i] = 32'(longint'($floor(x * 4294967296.0)));
    end
    empty_blk = 512'h80;
    abc_blk = (512'h18 << 448) | 512'h80636261;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", ra, 1);
    check("rst_out_valid", ova, 0);
    check("rst_busy", busy_a, 0);
    check("rst_out_state", out_a, 0);
    check("rst_b_out_state", out_b, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    send(0, IV, empty_blk, w);
    check("empty_accept_wait", w, 0);
    wait_out(0, 64, "empty_latency");
    check("empty_vector", out_a, EMPTY_RES);
    @(posedge clk); #1;

    send(0, IV, abc_blk, w);
    wait_out(0, 64, "abc_latency_s1");
    check("abc_vector", out_a, ABC_RES);
    @(posedge clk); #1;

    ora = 0;
    send(0, rnd128(), rnd512(), w);
    wait_out(0, 64, "bp_latency");
    snap = out_a;
    va = 1; st_a = rnd128(); bk_a = rnd512();
    repeat (10) begin
      @(posedge clk); #1;
      check("bp_out_valid", ova, 1);
      check("bp_out_stable", out_a, snap);
      check("bp_in_ready", ra, 0);
    end
    va = 0; ora = 1;
    @(posedge clk); #1;
    check("bp_ready_after_take", ra, 1);
    repeat (70) @(posedge clk);
    #1;
    check("bp_ignored_busy", busy_a, 0);
    check("bp_idle_holds", out_a, snap);

    send(0, IV, abc_blk, w);
    repeat (30) @(posedge clk);
    #3 rst_n = 0;
    #1;
    check("midrst_out_valid", ova, 0);
    check("midrst_out_state", out_a, 0);
    check("midrst_in_ready", ra, 1);
    check("midrst_busy", busy_a, 0);
    qa.delete();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    send(0, IV, abc_blk, w);
    check("rerun_accept_wait", w, 0);
    wait_out(0, 64, "rerun_latency");
    check("rerun_abc", out_a, ABC_RES);

    @(posedge clk); #1;
    ora = 1;
    send(0, rnd128(), rnd512(), w);
    wait_out(0, 64, "b2b_first_latency");
    send(0, rnd128(), rnd512(), w);
    check("b2b_gap", w, 1);
    wait_out(0, 64, "b2b_second_latency");
    @(posedge clk); #1;

    for (int r = 0; r < 6; r++) begin
      int n = 0;
      send(0, rnd128(), rnd512(), w);
      while (qa.size() > 0 && n < 400) begin
        ora = 1'($urandom_range(0, 1));
        @(posedge clk); #1; n++;
      end
      if (qa.size() > 0) fail("rand_drain_timeout");
    end
    ora = 1;

    send(1, IV, abc_blk, w);
    wait_out(1, 16, "abc_latency_s4");
    check("abc_raw", out_b, sub4(ABC_RES, IV));
    @(posedge clk); #1;
    for (int r = 0; r < 3; r++) begin
      send(1, rnd128(), rnd512(), w);
      wait_out(1, 16, "b_rand_latency");
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    #1;
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md5_compress.md
MD5_COMPRESS -- requirements
Module: md5_compress

Interface
REQ-001 SHALL have parameter STEPS_PER_CYCLE, default 1, the number of MD5 steps unrolled per clock; legal values are 1, 2 and 4.
REQ-002 SHALL have parameter ADD_CHAIN, default 1; when 1 the chaining input is added to the result, when 0 the raw working state is output.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the engine can accept a request.
REQ-007 SHALL have port in_state, input, 128 bits: a at [31:0], b at [63:32], c at [95:64], d at [127:96].
REQ-008 SHALL have port in_block, input, 512 bits: message word M[j] at [32j+31:32j], with little-endian byte order inside each word.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port out_state, output, 128 bits, packed the same way as in_state.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE; in_ready is 1 only in IDLE.
REQ-014 SHALL, on an edge with in_valid=1 and in_ready=1, register in_state and in_block, set the working state to in_state, clear the step counter i, and enter RUN.
REQ-015 SHALL, on each RUN edge, perform steps i through i+S-1 (S = STEPS_PER_CYCLE) and advance i by S; i wraps 63 to 0 only on leaving RUN.
REQ-016 SHALL compute each step i in round r = i/16 as follows:
- f selection: r0 F=(b&c)|(~b&d); r1 G=(b&d)|(c&~d); r2 H=b^c^d; r3 I=c^(b|~d).
- message index g: r0 i; r1 (5i+1) mod 16; r2 (3i+5) mod 16; r3 7i mod 16.
- sum = a+f+K[i]+M[g] mod 2^32.
- next a'=d, b'=b+rotl(sum,s[i]) mod 2^32, c'=b, d'=c.
REQ-017 SHALL use K[i] = floor(|sin(i+1)|*2^32) for i = 0..63.
REQ-018 SHALL use rotate amounts per round of 7/12/17/22, 5/9/14/20, 4/11/16/23 and 6/10/15/21, cycling with i mod 4.
REQ-019 SHALL, on the edge completing step 63, load out_state with the word-wise mod-2^32 sum of registered in_state and the working state (ADD_CHAIN=1), or with the working state alone (ADD_CHAIN=0), and enter DONE.
REQ-020 SHALL assert out_valid exactly 64/S clock edges after the accepting edge (64 for S=1, 16 for S=4).
REQ-021 SHALL hold out_valid=1 and out_state stable in DONE until an edge with out_ready=1, then enter IDLE, so that in_ready=1 in the following cycle.
REQ-022 SHALL ignore in_valid while in RUN or DONE, with no effect on the computation in progress.
REQ-023 SHALL keep out_state holding the last result in IDLE and RUN, with out_valid=0.
REQ-024 SHALL perform all additions modulo 2^32 per word, with no carry between words.

Reset
REQ-025 SHALL, on rst_n=0 at any time including mid-RUN or in DONE, immediately force IDLE, i=0, in_ready=1, out_valid=0, busy=0, out_state=0 and a cleared working state.
REQ-026 SHALL, after rst_n deasserts, accept a request at the first rising edge with in_valid=1; the aborted computation produces no output.

Structure
REQ-027 SHALL place the K[0..63] table, the rotate table, the round-function enum, the message-index function and the FSM state typedef in the shared package md5_pkg.
REQ-028 SHALL implement one step as a combinational sub-module md5_step (inputs: a/b/c/d, M word, step index; outputs: next a/b/c/d), instantiated STEPS_PER_CYCLE times in a chain.
REQ-029 SHALL register only the working state, the message block, the chaining copy, i, the FSM state and out_state.

Verification
REQ-030 SHALL cover the empty message: IV 67452301/efcdab89/98badcfe/10325476 with M[0]=00000080 and all other words 0 -> out_state a=d98c1dd4, b=04b2008f, c=980980e9, d=7e42f8ec.
REQ-031 SHALL cover "abc": same IV with M[0]=80636261, M[14]=00000018 and other words 0 -> a=98500190, b=b04fd23c, c=7d3f96d6, d=727fe128, with out_valid after 64 edges at S=1 and after 16 edges at S=4.
REQ-032 SHALL cover backpressure: out_ready=0 for 10 cycles -> out_valid and out_state stable, in_ready=0, and a new in_valid is ignored.
REQ-033 SHALL cover reset mid-operation: rst_n=0 at step 30 -> out_valid=0 and out_state=0 immediately; re-running "abc" then gives the REQ-031 result.
REQ-034 SHALL cover ADD_CHAIN=0: the "abc" vector -> out_state equals the REQ-031 result minus the IV per word, mod 2^32.
REQ-035 SHALL cover back-to-back operation: two requests with out_ready tied to 1 -> second acceptance one cycle after the first output handshake, and both results correct.
